mine_placer: RTL and testbench

MINE_PLACER -- requirements
Module: mine_placer

---
 rtl/mine_placer.sv | 121 ++++++++++++
 tb/tb_mine_placer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mine_placer.sv
`default_nettype none
// ============================================================================
//  Module      : mine_placer
//  Description : Generates a random 8x8 minesweeper mine map. A 6-bit LFSR
//                chooses candidate cells. If the chosen cell already holds a
//                mine, the probe moves to the next cell instead, so the run
//                always finishes.
//  Ports       : clk          - rising-edge clock
//                rst          - synchronous active-high reset
//                start        - request a new map; honoured only while idle
//                bomb_count   - number of mines to place (0..63)
//                mine_map     - bit i = mine in cell i (row i/8, col i%8)
//                placed_count - mines placed so far in the current map
//                busy         - high from the cycle after an accepted start
//                               through the done cycle
//                done         - one-cycle pulse when the map is complete
//  Revision    : 1.0 - initial release
// ============================================================================
module mine_placer #(
    parameter logic [5:0] SEED  = 6'h01,
    parameter int         CELLS = 64      // fixed 8x8 board; only 64 supported
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       bomb_count,
    output logic [CELLS-1:0] mine_map,
    output logic [5:0]       placed_count,
    output logic             busy,
    output logic             done
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [5:0] c_seed = (SEED == 6'h00) ? 6'h01 : SEED;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PROBE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [5:0]       r_lfsr;
    logic [5:0]       r_idx;
    logic [5:0]       r_target;
    logic [CELLS-1:0] r_map;
    logic [5:0]       r_count;

    logic [1:0]       w_state_nxt;
    logic [5:0]       w_lfsr_nxt;
    logic [5:0]       w_idx_nxt;
    logic [5:0]       w_target_nxt;
    logic [CELLS-1:0] w_map_nxt;
    logic [5:0]       w_count_nxt;

    // x^6 + x^5 + 1: maximal length, so every non-zero state is visited.
    assign w_lfsr_nxt = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_target_nxt = r_target;
        w_map_nxt    = r_map;
        w_count_nxt  = r_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_target_nxt = bomb_count;
                    w_map_nxt    = '0;
                    w_count_nxt  = 6'd0;
                    w_idx_nxt    = r_lfsr;
                    w_state_nxt  = (bomb_count == 6'd0) ? S_DONE : S_PROBE;
                end
            end
            S_PROBE: begin
                if (!r_map[r_idx]) begin
                    w_map_nxt[r_idx] = 1'b1;
                    w_count_nxt      = r_count + 6'd1;
                    w_idx_nxt        = r_lfsr;
                    if (w_count_nxt == r_target) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    // Collision: walk to the next cell. The 6-bit add wraps
                    // 63 to 0, and the target is at most 63, so a free cell
                    // is always reached within 64 steps.
                    w_idx_nxt = r_idx + 6'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lfsr   <= c_seed;
            r_idx    <= 6'd0;
            r_target <= 6'd0;
            r_map    <= '0;
            r_count  <= 6'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_idx    <= w_idx_nxt;
            r_target <= w_target_nxt;
            r_map    <= w_map_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign mine_map     = r_map;
    assign placed_count = r_count;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mine_placer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mine_placer
//  Description : Directed self-checking bench for mine_placer. Includes a
//                second instance with SEED=0 to show the seed substitution.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mine_placer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  bomb_count;
    logic [63:0] mine_map;
    logic [5:0]  placed_count;
    logic        busy;
    logic        done;
    logic [63:0] mine_map_z;
    logic [5:0]  placed_count_z;
    logic        busy_z;
    logic        done_z;

    int          n_asrt = 0;
    int          n_fail = 0;
    int          n_done = 0;
    logic [5:0]  m_lfsr;
    logic [5:0]  m_l0;

    mine_placer #(.SEED(6'h01), .CELLS(64)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bomb_count(bomb_count),
        .mine_map(mine_map), .placed_count(placed_count),
        .busy(busy), .done(done)
    );

    mine_placer #(.SEED(6'h00), .CELLS(64)) u_dut_zero_seed (
        .clk(clk), .rst(rst), .start(start), .bomb_count(bomb_count),
        .mine_map(mine_map_z), .placed_count(placed_count_z),
        .busy(busy_z), .done(done_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] lfsr_step(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    // Reference LFSR, tracked independently of the DUT.
    always @(posedge clk) begin
        m_lfsr <= rst ? 6'h01 : lfsr_step(m_lfsr);
        if (!rst && done) n_done <= n_done + 1;
    end

    // Algorithmic reference: expected map and start-to-done latency.
    task automatic model(input logic [5:0] l0, input logic [5:0] tgt,
                         output logic [63:0] map, output int lat);
        logic [5:0] idx;
        logic [5:0] l;
        int         cnt;
        map = '0;
        lat = 1;
        idx = l0;
        l   = lfsr_step(l0);
        cnt = 0;
        while (cnt < int'(tgt)) begin
            lat++;
            if (!map[idx]) begin
                map[idx] = 1'b1;
                cnt++;
                idx = l;
            end else begin
                idx = idx + 6'd1;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; presents start for one rising edge and
    // then scrambles bomb_count so only the accepted edge can matter.
    task automatic start_pulse(input logic [5:0] cnt);
        start      = 1'b1;
        bomb_count = cnt;
        m_l0       = m_lfsr;
        @(posedge clk);
        #1;
        start      = 1'b0;
        bomb_count = ~cnt;
    endtask

    task automatic wait_done(input int bound, output int lat, output logic to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    logic [63:0] exp_map;
    int          exp_lat;
    int          lat;
    logic        to;
    int          done_snap;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        bomb_count = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_map",   mine_map, 64'h0);
        check("reset_count", {58'd0, placed_count}, 64'd0);
        check("reset_busy",  {63'd0, busy}, 64'd0);
        check("reset_done",  {63'd0, done}, 64'd0);

        // Basic placement: first cycle after reset, two mines -> cells 1, 2.
        rst = 1'b0;
        start_pulse(6'd2);
        wait_done(10, lat, to);
        check("basic_timeout", {63'd0, to}, 64'd0);
        check("basic_latency", lat, 64'd3);
        check("basic_map",     mine_map, 64'h6);
        check("basic_count",   {58'd0, placed_count}, 64'd2);
        check("basic_busy",    {63'd0, busy}, 64'd1);
        check("zero_seed_map", mine_map_z, 64'h6);
        @(negedge clk);
        check("basic_done_width", {63'd0, done}, 64'd0);
        check("basic_busy_after", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        check("basic_hold_map", mine_map, 64'h6);

        // Zero mines, then a start presented during the done cycle.
        start_pulse(6'd0);
        @(negedge clk);
        check("zero_busy", {63'd0, busy}, 64'd1);
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_map",  mine_map, 64'h0);
        start_pulse(6'd5);
        @(negedge clk);
        check("done_start_ignored", {63'd0, busy}, 64'd0);
        check("done_start_count",   {58'd0, placed_count}, 64'd0);

        // Dense map: collision walk to 63 mines.
        start_pulse(6'd63);
        model(m_l0, 6'd63, exp_map, exp_lat);
        wait_done(4033, lat, to);
        check("full_timeout",  {63'd0, to}, 64'd0);
        check("full_latency",  lat, exp_lat);
        check("full_popcount", $countones(mine_map), 64'd63);
        check("full_map",      mine_map, exp_map);
        check("full_count",    {58'd0, placed_count}, 64'd63);

        // Start during PROBE must be ignored.
        @(negedge clk);
        start_pulse(6'd16);
        model(m_l0, 6'd16, exp_map, exp_lat);
        repeat (4) @(negedge clk);
        start_pulse(6'd32);
        wait_done(4033, lat, to);
        check("busy_timeout", {63'd0, to}, 64'd0);
        check("busy_count",   {58'd0, placed_count}, 64'd16);
        check("busy_map",     mine_map, exp_map);

        // Reset in the middle of a placement run.
        @(negedge clk);
        start_pulse(6'd8);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_snap = n_done;
        @(negedge clk);
        check("rst_mid_map",   mine_map, 64'h0);
        check("rst_mid_busy",  {63'd0, busy}, 64'd0);
        check("rst_mid_count", {58'd0, placed_count}, 64'd0);
        repeat (20) @(negedge clk);
        check("rst_mid_no_done", n_done, done_snap);

        // Back-to-back runs.
        done_snap = n_done;
        start_pulse(6'd4);
        model(m_l0, 6'd4, exp_map, exp_lat);
        wait_done(100, lat, to);
        check("b2b1_timeout", {63'd0, to}, 64'd0);
        check("b2b1_latency", lat, exp_lat);
        check("b2b1_map",     mine_map, exp_map);
        @(negedge clk);
        check("b2b1_done_once", n_done, done_snap + 1);
        start_pulse(6'd8);
        model(m_l0, 6'd8, exp_map, exp_lat);
        @(negedge clk);
        check("b2b2_cleared_map",   mine_map, 64'h0);
        check("b2b2_cleared_count", {58'd0, placed_count}, 64'd0);
        wait_done(100, lat, to);
        check("b2b2_timeout",  {63'd0, to}, 64'd0);
        check("b2b2_latency",  lat + 1, exp_lat);
        check("b2b2_popcount", $countones(mine_map), 64'd8);
        check("b2b2_map",      mine_map, exp_map);
        @(negedge clk);
        check("b2b2_done_once", n_done, done_snap + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
